// File: rtl/mult_err_acc.sv
// Error-statistics accumulator behind the 8x8 approximate multipliers.
// Collects sum, max and count of |p_acc - p_apx| over a batch of N_SAMPLES pairs.
//
// state | meaning
// IDLE  | waiting for start, statistics hold reset/cleared values
// RUN   | accepting product pairs, one per handshake
// DRAIN | no new pairs, letting the two-stage pipeline empty
// DONE  | batch complete, statistics stable until next start
module mult_err_acc #(
    parameter int W         = 16,
    parameter int N_SAMPLES = 50,
    parameter int CNT_W     = 8,
    parameter int ACC_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     p_acc,
    input  logic [W-1:0]     p_apx,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum_err,
    output logic [W-1:0]     max_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;
    logic             start_ok;
    logic [1:0]       drain_cnt;
    logic [W:0]       diff_w;
    logic [W-1:0]     mag;
    logic             v1;
    logic [W-1:0]     d1;
    logic             ne1;
    logic [ACC_W:0]   sum_ext;

    assign accept   = in_valid && in_ready;
    assign last     = accept && (sample_cnt == CNT_W'(N_SAMPLES - 1));
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

    // W+1 bit difference; negate the low W bits when the sign bit is set
    assign diff_w = {1'b0, p_acc} - {1'b0, p_apx};
    assign mag    = diff_w[W] ? (~diff_w[W-1:0] + W'(1)) : diff_w[W-1:0];

    assign sum_ext = {1'b0, sum_err} + (ACC_W + 1)'(d1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain timer: loaded on the final acceptance, DONE at terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= 2'd0;
        end else if ((state == S_RUN) && last) begin
            drain_cnt <= 2'd1;
        end else if ((state == S_DRAIN) && (drain_cnt != 2'd0)) begin
            drain_cnt <= drain_cnt - 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == 2'd0) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            d1  <= '0;
            ne1 <= 1'b0;
        end else if (start_ok) begin
            v1 <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                d1  <= mag;
                ne1 <= (mag != '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_err    <= '0;
            max_err    <= '0;
            err_cnt    <= '0;
            sample_cnt <= '0;
        end else if (start_ok) begin
            sum_err    <= '0;
            max_err    <= '0;
            err_cnt    <= '0;
            sample_cnt <= '0;
        end else begin
            if (accept) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            if (v1) begin
                sum_err <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
                if (d1 > max_err) begin
                    max_err <= d1;
                end
                err_cnt <= err_cnt + CNT_W'(ne1);
            end
        end
    end

endmodule

// File: doc/mult_err_acc.md
Name: mult_err_acc

Overview:
- Sequential error-statistics accumulator placed directly downstream of the 8x8 unsigned radix-4 multipliers.
- Consumes one accurate/approximate product pair per handshake and computes the absolute error distance for each pair.
- Over a programmed batch it accumulates the sum of error distances, the maximum error distance, and the count of erroneous samples.
- When the batch completes it raises done; the results are used for MED/ER characterisation of approximate multiplier variants.

Parameters:
- W, 16, product width; matches the 8x8 multiplier output.
- N_SAMPLES, 50, number of accepted pairs per batch; must be at least 1.
- CNT_W, 8, width of the sample and error counters; must satisfy 2^CNT_W > N_SAMPLES.
- ACC_W, 32, width of the error-sum accumulator.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; clears the statistics and begins a batch (honoured in IDLE and DONE only).
- in_valid  in  1  product pair present on p_acc/p_apx.
- in_ready  out  1  block can accept a pair this cycle.
- p_acc  in  W  accurate product.
- p_apx  in  W  approximate product.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  batch complete; statistics are stable.
- sum_err  out  ACC_W  sum of |p_acc - p_apx|, saturating.
- max_err  out  W  maximum |p_acc - p_apx| in the batch.
- err_cnt  out  CNT_W  number of pairs with p_acc != p_apx.
- sample_cnt  out  CNT_W  number of pairs accepted in the current batch.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=0, busy=0, done=0; sum_err, max_err, err_cnt, sample_cnt = 0; pipeline valid flags = 0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN; clears all statistics on the same edge.
  - RUN: in_ready=1. A pair is accepted when in_valid && in_ready; sample_cnt increments on acceptance. When the N_SAMPLES-th pair is accepted -> DRAIN, and in_ready drops on the next cycle.
  - DRAIN: in_ready=0; held 2 cycles until the pipeline is empty -> DONE.
  - DONE: done=1 and all outputs held. start -> clear statistics and go to RUN; done deasserts on the following cycle.
- start while in RUN or DRAIN is ignored.
- Input data is ignored when in_ready=0, regardless of in_valid.
- Pipeline:
  - Stage 1 registers d = |p_acc - p_apx|. The subtraction is computed at W+1 bits and the magnitude is W bits, so it is exact for unsigned inputs. Stage 1 also registers the flag ne = (d != 0).
  - Stage 2 updates the accumulators: sum_err += d, max_err = max(max_err, d), err_cnt += ne.
  - An accepted pair is visible in sum_err, max_err and err_cnt two clock edges after acceptance. sample_cnt is visible one edge after acceptance.
- Arithmetic:
  - d is zero-extended to ACC_W before addition.
  - sum_err saturates at 2^ACC_W-1 and never wraps.
  - err_cnt cannot exceed N_SAMPLES.
  - A tie in max_err leaves the value unchanged.
- Back-to-back acceptance is allowed every cycle in RUN, giving a throughput of 1 pair per clock.
- in_valid gaps stall acceptance only; statistics are unaffected by idle cycles.
- Reset mid-batch: immediate clear to IDLE. Partial results are discarded and pairs in flight are dropped.
- N_SAMPLES=1: one acceptance moves RUN->DRAIN; done rises 3 cycles after acceptance.

Test Plan:
- Reset during RUN after 10 accepted pairs -> all outputs 0 and in_ready=0 immediately (asynchronous); a later start runs a clean batch.
- start, then 50 pairs with p_acc=p_apx=16'd1200 every cycle -> done=1; sum_err=0, max_err=0, err_cnt=0, sample_cnt=50; in_ready low after the 50th acceptance.
- 50 pairs where pairs 0..4 have p_acc=100, p_apx=90 and the rest match -> sum_err=50, max_err=10, err_cnt=5.
- Both subtraction signs: one pair with p_acc=0, p_apx=65025 (255*255) and one with p_acc=65025, p_apx=0, rest equal -> sum_err=130050, max_err=65025, err_cnt=2.
- ACC_W=17 build, 50 pairs each with d=65025 -> sum_err saturates at 131071.
- Handshake and timing checks:
  - in_valid toggled 1,0,1,0,... -> batch completes only after 50 accepted pairs; latency matches acceptance+2.
  - start pulsed during RUN -> ignored.
  - start in DONE -> statistics clear and done drops next cycle.
